// File: rtl/npu_pkg.sv
// Shared NPU port definitions: select/op codes, segment sizes and loader state.
package npu_pkg;

  localparam logic [2:0] SEL_IMG = 3'd0;
  localparam logic [2:0] SEL_WC1 = 3'd1;
  localparam logic [2:0] SEL_WC2 = 3'd2;
  localparam logic [2:0] SEL_WF1 = 3'd3;
  localparam logic [2:0] SEL_WF2 = 3'd4;
  localparam logic [2:0] SEL_OP  = 3'd5;

  localparam logic [11:0] OP_RST  = 12'd0;
  localparam logic [11:0] OP_TRIG = 12'd1;
  localparam logic [11:0] OP_REQ  = 12'd2;

  localparam int IMG_BYTES = 240;
  localparam int WC1_BYTES = 90;
  localparam int WC2_BYTES = 90;
  localparam int WF1_BYTES = 1320;
  localparam int WF2_BYTES = 10;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LOAD, S_TRIG, S_WAIT, S_REQ, S_READ, S_OUT
  } ldr_state_e;

  typedef struct packed {
    logic        en;
    logic [14:0] addr;
    logic [31:0] data;
  } npu_wr_t;

  function automatic npu_wr_t op_wr(input logic [11:0] op);
    op_wr = '{en: 1'b1, addr: {SEL_OP, op}, data: 32'd0};
  endfunction

endpackage

// File: rtl/npu_seg_addr_gen.sv
// Segment/index walker over the image and weight regions of the NPU write port.
module npu_seg_addr_gen
  import npu_pkg::*;
#(
  parameter int IMG_SIZE = IMG_BYTES,
  parameter int WC1_SIZE = WC1_BYTES,
  parameter int WC2_SIZE = WC2_BYTES,
  parameter int WF1_SIZE = WF1_BYTES,
  parameter int WF2_SIZE = WF2_BYTES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        step,
  input  logic        skip,
  output logic [2:0]  seg,
  output logic [11:0] idx,
  output logic        last_byte,
  output logic        last_seg
);

  logic [11:0] seg_max;

  always_comb begin
    seg_max = 12'(WF2_SIZE - 1);
    case (seg)
      SEL_IMG: seg_max = 12'(IMG_SIZE - 1);
      SEL_WC1: seg_max = 12'(WC1_SIZE - 1);
      SEL_WC2: seg_max = 12'(WC2_SIZE - 1);
      SEL_WF1: seg_max = 12'(WF1_SIZE - 1);
      default: seg_max = 12'(WF2_SIZE - 1);
    endcase
  end

  assign last_byte = (idx == seg_max);
  // An image-only job ends after the image segment; weights stay resident in the NPU.
  assign last_seg  = skip ? (seg == SEL_IMG) : (seg == SEL_WF2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEL_IMG;
      idx <= 12'd0;
    end else if (clear) begin
      seg <= SEL_IMG;
      idx <= 12'd0;
    end else if (step) begin
      if (last_byte) begin
        seg <= seg + 3'd1;
        idx <= 12'd0;
      end else begin
        idx <= idx + 12'd1;
      end
    end
  end

endmodule

// File: rtl/npu_host_loader.sv
// Host-side loader: replays a byte stream as NPU writes, triggers, waits and returns the logit.
module npu_host_loader
  import npu_pkg::*;
#(
  parameter int IMG_SIZE = IMG_BYTES,
  parameter int WC1_SIZE = WC1_BYTES,
  parameter int WC2_SIZE = WC2_BYTES,
  parameter int WF1_SIZE = WF1_BYTES,
  parameter int WF2_SIZE = WF2_BYTES,
  parameter int TIMEOUT  = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        skip_weights,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        npu_en,
  output logic [14:0] npu_addr,
  output logic [31:0] npu_w_data,
  input  logic [31:0] npu_r_data,
  input  logic        npu_done,
  output logic        busy,
  output logic        res_valid,
  output logic [23:0] res_data,
  output logic        res_err,
  input  logic        res_ready
);

  ldr_state_e  state, state_nx;
  npu_wr_t     wr_nx;
  logic        skip_q, hs, tmo_hit;
  logic [15:0] wait_cnt;
  logic [2:0]  seg;
  logic [11:0] idx;
  logic        last_byte, last_seg;
  logic        unused_rdata;

  assign unused_rdata = ^npu_r_data[31:24];
  assign s_ready      = (state == S_LOAD);
  assign busy         = (state != S_IDLE);
  assign hs           = s_valid & s_ready;
  assign tmo_hit      = (wait_cnt == 16'(TIMEOUT));

  npu_seg_addr_gen #(
    .IMG_SIZE(IMG_SIZE), .WC1_SIZE(WC1_SIZE), .WC2_SIZE(WC2_SIZE),
    .WF1_SIZE(WF1_SIZE), .WF2_SIZE(WF2_SIZE)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state == S_CLR),
    .step     (hs),
    .skip     (skip_q),
    .seg      (seg),
    .idx      (idx),
    .last_byte(last_byte),
    .last_seg (last_seg)
  );

  // REQ is issued on the WAIT exit so it lands in the REQ cycle and READ samples one cycle later.
  always_comb begin
    state_nx = state;
    wr_nx    = '0;
    case (state)
      S_IDLE: if (start) state_nx = S_CLR;
      S_CLR: begin
        wr_nx    = op_wr(OP_RST);
        state_nx = S_LOAD;
      end
      S_LOAD: if (hs) begin
        wr_nx = '{en: 1'b1, addr: {seg, idx}, data: {24'd0, s_data}};
        if (last_byte && last_seg) state_nx = S_TRIG;
      end
      S_TRIG: begin
        wr_nx    = op_wr(OP_TRIG);
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (npu_done) begin
          wr_nx    = op_wr(OP_REQ);
          state_nx = S_REQ;
        end else if (tmo_hit) begin
          state_nx = S_OUT;
        end
      end
      S_REQ:  state_nx = S_READ;
      S_READ: state_nx = S_OUT;
      S_OUT:  if (res_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      skip_q     <= 1'b0;
      wait_cnt   <= 16'd0;
      npu_en     <= 1'b0;
      npu_addr   <= 15'd0;
      npu_w_data <= 32'd0;
      res_valid  <= 1'b0;
      res_data   <= 24'd0;
      res_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      npu_en     <= wr_nx.en;
      npu_addr   <= wr_nx.addr;
      npu_w_data <= wr_nx.data;
      if (state == S_IDLE && start) skip_q <= skip_weights;
      if (state == S_TRIG) wait_cnt <= 16'd0;
      else if (state == S_WAIT && wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'd1;
      if (state == S_READ) begin
        res_valid <= 1'b1;
        res_err   <= 1'b0;
        res_data  <= npu_r_data[23:0];
      end
      if (state == S_WAIT && !npu_done && tmo_hit) begin
        res_valid <= 1'b1;
        res_err   <= 1'b1;
        res_data  <= 24'd0;
      end
      if (state == S_OUT && res_ready) begin
        res_valid <= 1'b0;
        res_err   <= 1'b0;
      end
    end
  end

endmodule
